clk_div_prog: RTL and testbench

//   Runtime-programmable clock divider / tick generator. Divides clk by a

---
 rtl/clk_div_prog.sv | 103 ++++++++++
 tb/tb_clk_div_prog.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Programmable clock divider. Emits a tick every N enabled cycles, plus a near-50% clkout
// and a modulo tick counter with carry. A new ratio is staged and only takes effect at a period boundary.
module clk_div_prog #(
  parameter int WIDTH       = 27,
  parameter int DEFAULT_DIV = 100000000,
  parameter int TICK_MOD    = 60,
  localparam int CNT_W      = (TICK_MOD > 2) ? $clog2(TICK_MOD) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             div_wr,
  input  logic [WIDTH-1:0] div_val,
  output logic             div_ack,
  output logic             tick,
  output logic             clkout,
  output logic [CNT_W-1:0] tick_cnt,
  output logic             carry
);

  logic [WIDTH-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] div_q, div_n;
  logic [WIDTH-1:0] pend_val, pend_val_n;
  logic             pend, pend_n;
  logic [CNT_W-1:0] tick_cnt_n;
  logic             tick_n, carry_n, div_ack_n, clkout_n;
  logic             wrap;

  assign wrap = en && !sync_clr && (cnt == div_q - WIDTH'(1));

  always_comb begin
    cnt_n      = cnt;
    div_n      = div_q;
    pend_n     = pend;
    pend_val_n = pend_val;
    tick_cnt_n = tick_cnt;
    tick_n     = 1'b0;
    carry_n    = 1'b0;
    div_ack_n  = 1'b0;

    if (sync_clr) begin
      cnt_n      = '0;
      tick_cnt_n = '0;
      if (pend) begin
        div_n     = pend_val;
        pend_n    = 1'b0;
        div_ack_n = 1'b1;
      end
    end else if (en) begin
      if (wrap) begin
        cnt_n  = '0;
        tick_n = 1'b1;
        if (tick_cnt == CNT_W'(TICK_MOD - 1)) begin
          tick_cnt_n = '0;
          carry_n    = 1'b1;
        end else begin
          tick_cnt_n = tick_cnt + CNT_W'(1);
        end
        if (pend) begin
          div_n     = pend_val;
          pend_n    = 1'b0;
          div_ack_n = 1'b1;
        end
      end else begin
        cnt_n = cnt + WIDTH'(1);
      end
    end

    // A write in the same cycle as an apply is staged for the following boundary.
    if (div_wr) begin
      pend_val_n = (div_val < WIDTH'(2)) ? WIDTH'(2) : div_val;
      pend_n     = 1'b1;
    end

    clkout_n = (cnt_n < (div_n - (div_n >> 1)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      div_q    <= WIDTH'(DEFAULT_DIV);
      pend     <= 1'b0;
      pend_val <= '0;
      tick     <= 1'b0;
      carry    <= 1'b0;
      div_ack  <= 1'b0;
      clkout   <= 1'b1;
      tick_cnt <= '0;
    end else begin
      cnt      <= cnt_n;
      div_q    <= div_n;
      pend     <= pend_n;
      pend_val <= pend_val_n;
      tick     <= tick_n;
      carry    <= carry_n;
      div_ack  <= div_ack_n;
      clkout   <= clkout_n;
      tick_cnt <= tick_cnt_n;
    end
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed scenarios plus random traffic.
// Each cycle's outputs are compared against a period/phase model.
module tb_clk_div_prog;
  localparam int WIDTH = 8;
  localparam int DDIV  = 4;
  localparam int TMOD  = 3;
  localparam int CW    = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0, sync_clr = 1'b0, div_wr = 1'b0;
  logic [WIDTH-1:0] div_val = '0;
  logic             div_ack, tick, clkout, carry;
  logic [CW-1:0]    tick_cnt;

  int n_chk = 0, n_fail = 0;

  // Model state: position in period, active ratio, staged ratio, tick count.
  int m_phase, m_n, m_pend, m_pval, m_tc;
  int m_tick, m_carry, m_ack;

  clk_div_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(DDIV), .TICK_MOD(TMOD)) dut (
    .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr), .div_wr(div_wr),
    .div_val(div_val), .div_ack(div_ack), .tick(tick), .clkout(clkout),
    .tick_cnt(tick_cnt), .carry(carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_n = DDIV; m_pend = 0; m_pval = 0; m_tc = 0;
    m_tick = 0; m_carry = 0; m_ack = 0;
  endtask

  task automatic model_step(input int e, input int sc, input int wr, input int val);
    m_tick = 0; m_carry = 0; m_ack = 0;
    if (sc != 0) begin
      m_phase = 0; m_tc = 0;
      if (m_pend != 0) begin m_n = m_pval; m_pend = 0; m_ack = 1; end
    end else if (e != 0) begin
      m_phase++;
      if (m_phase == m_n) begin
        m_phase = 0; m_tick = 1;
        m_tc = (m_tc + 1) % TMOD;
        m_carry = (m_tc == 0);
        if (m_pend != 0) begin m_n = m_pval; m_pend = 0; m_ack = 1; end
      end
    end
    if (wr != 0) begin
      m_pval = (val < 2) ? 2 : val;
      m_pend = 1;
    end
  endtask

  task automatic check_outputs();
    chk("tick", int'(tick), m_tick);
    chk("carry", int'(carry), m_carry);
    chk("div_ack", int'(div_ack), m_ack);
    chk("tick_cnt", int'(tick_cnt), m_tc);
    chk("clkout", int'(clkout), (m_phase < (m_n + 1) / 2) ? 1 : 0);
  endtask

  // Called just after a posedge; drives inputs for the next edge, then checks its result.
  task automatic cycle(input int e, input int sc, input int wr, input int val);
    en = e[0]; sync_clr = sc[0]; div_wr = wr[0]; div_val = val[WIDTH-1:0];
    @(posedge clk);
    model_step(e, sc, wr, val);
    #1;
    check_outputs();
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) cycle(1, 0, 0, 0);
  endtask

  // Asynchronous reset pulse between edges; outputs must react without a clock.
  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    model_reset();
    chk("rst_tick", int'(tick), 0);
    chk("rst_carry", int'(carry), 0);
    chk("rst_ack", int'(div_ack), 0);
    chk("rst_clkout", int'(clkout), 1);
    chk("rst_tick_cnt", int'(tick_cnt), 0);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    pulse_reset();

    // Default ratio: ticks every 4 cycles, clkout 1100.
    run(13);

    // Stage 5 while one cycle into the period: the current period stays 4.
    for (int i = 0; i < 8 && m_phase != 1; i++) cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 5);
    run(16);

    // Last write wins; a ratio of 1 clamps to 2.
    cycle(1, 0, 1, 0);
    cycle(1, 0, 1, 3);
    run(10);
    cycle(1, 0, 1, 1);
    run(9);

    // Freeze mid-period for three cycles.
    cycle(1, 0, 1, 6);
    run(8);
    for (int i = 0; i < 8 && m_phase != 2; i++) cycle(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    run(14);

    // Sync clear with a staged ratio at phase 2, plus a write in the same cycle.
    cycle(1, 0, 1, 4);
    for (int i = 0; i < 12 && m_phase != 2; i++) cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 7);
    for (int i = 0; i < 8 && m_phase != 2; i++) cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 5);
    run(20);

    // Reset while mid-period with a pending ratio.
    cycle(1, 0, 1, 7);
    run(1);
    pulse_reset();
    run(10);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      int e, sc, wr, val;
      e   = ($urandom_range(0, 9) != 0) ? 1 : 0;
      sc  = ($urandom_range(0, 39) == 0) ? 1 : 0;
      wr  = ($urandom_range(0, 14) == 0) ? 1 : 0;
      val = $urandom_range(0, 9);
      if ($urandom_range(0, 499) == 0) pulse_reset();
      else cycle(e, sc, wr, val);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
